// File: rtl/note_window_loader_pkg.sv
// rtl/note_window_loader_pkg.sv - note slot layout, empty/end encodings and sequencer state codes
// Shared with the pixel renderer and the song ROM generator.
package note_window_loader_pkg;

  localparam int DEF_DISPLAYED_BEATS    = 4;
  localparam int DEF_SIMULTANEOUS_NOTES = 2;
  localparam int DEF_BEAT_BITS          = 8;
  localparam int DEF_NOTE_BITS          = 6;
  localparam int DEF_ROM_ADDR_BITS      = 8;

  // Slot / ROM word layout, MSB to LSB: {note, start_beat, duration}
  localparam int DUR_LSB = 0;

  function automatic int start_lsb(input int beat_bits);
    return DUR_LSB + beat_bits;
  endfunction

  function automatic int note_lsb(input int beat_bits);
    return DUR_LSB + 2 * beat_bits;
  endfunction

  // A slot with zero duration is not drawn; a ROM word with zero duration ends the song
  localparam int EMPTY_DURATION       = 0;
  localparam int END_OF_SONG_DURATION = 0;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_EVICT      = 3'd1;
  localparam logic [2:0] ST_FETCH_REQ  = 3'd2;
  localparam logic [2:0] ST_FETCH_WAIT = 3'd3;
  localparam logic [2:0] ST_CHECK      = 3'd4;

  function automatic logic [DEF_NOTE_BITS+2*DEF_BEAT_BITS-1:0] pack_slot(
    input logic [DEF_NOTE_BITS-1:0] note,
    input logic [DEF_BEAT_BITS-1:0] start_beat,
    input logic [DEF_BEAT_BITS-1:0] duration
  );
    return {note, start_beat, duration};
  endfunction

endpackage

// File: rtl/note_window_loader_free_slot_finder.sv
// rtl/note_window_loader_free_slot_finder.sv - lowest-index empty slot priority encoder
module note_window_loader_free_slot_finder
  import note_window_loader_pkg::*;
#(
  parameter int SLOTS    = 16,
  parameter int DUR_BITS = 8,
  parameter int IDX_BITS = 4
) (
  input  logic [SLOTS-1:0][DUR_BITS-1:0] i_durations,
  output logic                           o_found,
  output logic [IDX_BITS-1:0]            o_index
);

  localparam logic [DUR_BITS-1:0] W_EMPTY = DUR_BITS'(EMPTY_DURATION);

  // Scanning downward lets the lowest empty index overwrite any higher one
  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (i_durations[i] == W_EMPTY) begin
        o_found = 1'b1;
        o_index = IDX_BITS'(i);
      end
    end
  end

endmodule

// File: rtl/note_window_loader.sv
// rtl/note_window_loader.sv - per-beat evict/load sequencer for the displayed-note slot array
module note_window_loader
  import note_window_loader_pkg::*;
#(
  parameter int DISPLAYED_BEATS    = DEF_DISPLAYED_BEATS,
  parameter int SIMULTANEOUS_NOTES = DEF_SIMULTANEOUS_NOTES,
  parameter int BEAT_BITS          = DEF_BEAT_BITS,
  parameter int NOTE_BITS          = DEF_NOTE_BITS,
  parameter int ROM_ADDR_BITS      = DEF_ROM_ADDR_BITS,
  localparam int NOTE_STATE_BITS   = NOTE_BITS + 2 * BEAT_BITS,
  localparam int NOTES_STATE_SIZE  = 2 * DISPLAYED_BEATS * SIMULTANEOUS_NOTES,
  localparam int SLOT_BITS         = $clog2(NOTES_STATE_SIZE)
) (
  input  logic                                              i_clk,
  input  logic                                              i_reset,
  input  logic                                              i_song_start,
  input  logic                                              i_new_beat,
  input  logic [BEAT_BITS-1:0]                              i_beat,
  output logic [ROM_ADDR_BITS-1:0]                          o_rom_addr,
  input  logic [NOTE_STATE_BITS-1:0]                        i_rom_data,
  output logic [NOTES_STATE_SIZE-1:0][NOTE_STATE_BITS-1:0]  o_notes,
  output logic                                              o_busy,
  output logic                                              o_overflow
);

  localparam int START_LSB = start_lsb(BEAT_BITS);
  localparam logic [BEAT_BITS-1:0] W_EMPTY = BEAT_BITS'(EMPTY_DURATION);
  localparam logic [BEAT_BITS-1:0] W_END   = BEAT_BITS'(END_OF_SONG_DURATION);
  localparam logic [BEAT_BITS:0]   W_DB    = (BEAT_BITS + 1)'(DISPLAYED_BEATS);
  localparam logic [SLOT_BITS-1:0] W_LAST  = SLOT_BITS'(NOTES_STATE_SIZE - 1);

  logic [2:0]                                       r_state;
  logic [BEAT_BITS-1:0]                             r_beat_q;
  logic [SLOT_BITS-1:0]                             r_idx;
  logic [ROM_ADDR_BITS-1:0]                         r_ptr;
  logic [NOTES_STATE_SIZE-1:0][NOTE_STATE_BITS-1:0] r_notes;
  logic                                             r_overflow;
  logic                                             r_pending;

  logic [BEAT_BITS:0]                    w_beat_ext;
  logic [BEAT_BITS:0]                    w_left_edge;
  logic [BEAT_BITS:0]                    w_right_edge;
  logic [BEAT_BITS:0]                    w_slot_end;
  logic                                  w_evict;
  logic                                  w_stop;
  logic [NOTES_STATE_SIZE-1:0][BEAT_BITS-1:0] w_durations;
  logic                                  w_found;
  logic [SLOT_BITS-1:0]                  w_free_idx;
  logic [ROM_ADDR_BITS-1:0]              w_ptr_next;

  // Window edges in one extra bit so late-song beats neither wrap nor go negative
  assign w_beat_ext   = {1'b0, r_beat_q};
  assign w_left_edge  = (w_beat_ext >= W_DB) ? (w_beat_ext - W_DB) : '0;
  assign w_right_edge = w_beat_ext + W_DB;

  assign w_slot_end = {1'b0, r_notes[r_idx][START_LSB +: BEAT_BITS]}
                    + {1'b0, r_notes[r_idx][DUR_LSB +: BEAT_BITS]};
  assign w_evict    = (r_notes[r_idx][DUR_LSB +: BEAT_BITS] != W_EMPTY)
                   && (w_slot_end <= w_left_edge);

  assign w_stop = (i_rom_data[DUR_LSB +: BEAT_BITS] == W_END)
               || ({1'b0, i_rom_data[START_LSB +: BEAT_BITS]} >= w_right_edge);

  assign w_ptr_next = (r_ptr == '1) ? r_ptr : (r_ptr + 1'b1);

  always_comb begin
    w_durations = '0;
    for (int i = 0; i < NOTES_STATE_SIZE; i++) begin
      w_durations[i] = r_notes[i][DUR_LSB +: BEAT_BITS];
    end
  end

  note_window_loader_free_slot_finder #(
    .SLOTS    (NOTES_STATE_SIZE),
    .DUR_BITS (BEAT_BITS),
    .IDX_BITS (SLOT_BITS)
  ) u_free_slot_finder (
    .i_durations (w_durations),
    .o_found     (w_found),
    .o_index     (w_free_idx)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_beat_q   <= '0;
      r_idx      <= '0;
      r_ptr      <= '0;
      r_notes    <= '0;
      r_overflow <= 1'b0;
      r_pending  <= 1'b0;
    end else if (i_song_start) begin
      // Also aborts any pass in flight; a coincident new_beat is subsumed
      r_state    <= ST_EVICT;
      r_beat_q   <= i_beat;
      r_idx      <= '0;
      r_ptr      <= '0;
      r_notes    <= '0;
      r_overflow <= 1'b0;
      r_pending  <= 1'b0;
    end else begin
      if (i_new_beat && (r_state != ST_IDLE)) begin
        r_pending <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_new_beat || r_pending) begin
            r_state   <= ST_EVICT;
            r_beat_q  <= i_beat;
            r_idx     <= '0;
            r_pending <= 1'b0;
          end
        end
        ST_EVICT: begin
          if (w_evict) begin
            r_notes[r_idx] <= '0;
          end
          if (r_idx == W_LAST) begin
            r_state <= ST_FETCH_REQ;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_FETCH_REQ:  r_state <= ST_FETCH_WAIT;
        ST_FETCH_WAIT: r_state <= ST_CHECK;
        ST_CHECK: begin
          // Stopping leaves the pointer on the unread entry so the next pass retries it
          if (w_stop) begin
            r_state <= ST_IDLE;
          end else begin
            if (w_found) begin
              r_notes[w_free_idx] <= i_rom_data;
            end else begin
              r_overflow <= 1'b1;
            end
            r_ptr   <= w_ptr_next;
            r_state <= ST_FETCH_REQ;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rom_addr = r_ptr;
  assign o_notes    = r_notes;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_note_window_loader.sv
// tb/tb_note_window_loader.sv - self-checking bench for note_window_loader against a beat-window model
module tb_note_window_loader;
  import note_window_loader_pkg::*;

  logic              clk;
  logic              reset;
  logic              song_start;
  logic              new_beat;
  logic [7:0]        beat;
  logic [7:0]        rom_addr;
  logic [21:0]       rom_data;
  logic [15:0][21:0] notes;
  logic              busy;
  logic              overflow;

  logic [21:0] rom [256];
  logic [21:0] m_notes [16];
  int          m_ptr;
  bit          m_ovf;
  int          checks;
  int          errors;

  note_window_loader dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_song_start (song_start),
    .i_new_beat   (new_beat),
    .i_beat       (beat),
    .o_rom_addr   (rom_addr),
    .i_rom_data   (rom_data),
    .o_notes      (notes),
    .o_busy       (busy),
    .o_overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [21:0] ent(input int n, input int s, input int d);
    return pack_slot(6'(n), 8'(s), 8'(d));
  endfunction

  task automatic model_song_start();
    for (int i = 0; i < 16; i++) m_notes[i] = '0;
    m_ptr = 0;
    m_ovf = 1'b0;
  endtask

  // One pass: drop notes fully left of [b-4, b+4), then pull ROM entries starting before b+4
  task automatic model_pass(input int b, output int k);
    int left, right, st, du, slot;
    left  = (b >= 4) ? b - 4 : 0;
    right = b + 4;
    for (int i = 0; i < 16; i++) begin
      du = int'(m_notes[i][7:0]);
      st = int'(m_notes[i][15:8]);
      if (du != 0 && st + du <= left) m_notes[i] = '0;
    end
    k = 0;
    for (int g = 0; g < 300; g++) begin
      du = int'(rom[m_ptr][7:0]);
      st = int'(rom[m_ptr][15:8]);
      if (du == 0 || st >= right) break;
      slot = -1;
      for (int i = 0; i < 16; i++) if (slot < 0 && m_notes[i][7:0] == 8'd0) slot = i;
      if (slot >= 0) m_notes[slot] = rom[m_ptr];
      else m_ovf = 1'b1;
      k++;
      if (m_ptr < 255) m_ptr++;
    end
  endtask

  task automatic do_song_start(input int b);
    @(negedge clk);
    song_start = 1'b1;
    beat       = 8'(b);
    @(negedge clk);
    song_start = 1'b0;
  endtask

  task automatic do_new_beat(input int b);
    @(negedge clk);
    new_beat = 1'b1;
    beat     = 8'(b);
    @(negedge clk);
    new_beat = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 3000) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic gen_rom(input int count, input int max_step);
    int s;
    s = 0;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    for (int i = 0; i < count; i++) begin
      s += int'($urandom_range(0, max_step));
      rom[i] = ent(int'($urandom_range(1, 63)), s, int'($urandom_range(1, 8)));
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (rom_addr !== 8'd0) begin errors++; $display("FAIL reset_rom_addr: got %0d expected 0", rom_addr); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (notes !== '0) begin errors++; $display("FAIL reset_notes: got %h expected 0", notes); end

    for (int i = 0; i < 256; i++) rom[i] = '0;
    for (int i = 0; i < 6; i++) rom[i] = ent(i + 1, 0, 8);
    do_song_start(0);
    n = 0;
    while (notes[2][7:0] == 8'd0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++; if (notes[2] !== ent(3, 0, 8)) begin errors++; $display("FAIL midpass_slot2: got %h expected %h", notes[2], ent(3, 0, 8)); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_song_start();
    checks++; if (notes !== '0) begin errors++; $display("FAIL midcheck_reset_notes: got %h expected 0", notes); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midcheck_reset_busy: got %b expected 0", busy); end
    checks++; if (rom_addr !== 8'd0) begin errors++; $display("FAIL midcheck_reset_rom_addr: got %0d expected 0", rom_addr); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midcheck_reset_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_basic();
    int k, cyc;
    int beats [3] = '{0, 3, 7};
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[0] = ent(5, 0, 2);
    rom[1] = ent(7, 1, 1);
    rom[2] = ent(9, 6, 1);
    model_song_start();
    for (int p = 0; p < 3; p++) begin
      model_pass(beats[p], k);
      if (p == 0) do_song_start(beats[p]);
      else do_new_beat(beats[p]);
      wait_idle(cyc);
      checks++; if (cyc != 16 + 3 * k + 3) begin errors++; $display("FAIL basic_latency beat %0d: got %0d expected %0d", beats[p], cyc, 16 + 3 * k + 3); end
      checks++; if (rom_addr !== 8'(m_ptr)) begin errors++; $display("FAIL basic_rom_addr beat %0d: got %0d expected %0d", beats[p], rom_addr, m_ptr); end
      for (int i = 0; i < 16; i++) begin
        checks++; if (notes[i] !== m_notes[i]) begin errors++; $display("FAIL basic_slot beat %0d slot %0d: got %h expected %h", beats[p], i, notes[i], m_notes[i]); end
      end
    end
    checks++; if (notes[2] !== ent(9, 6, 1) || notes[0] !== '0 || notes[1] !== '0) begin errors++; $display("FAIL basic_final: got %h %h %h expected 0 0 %h", notes[0], notes[1], notes[2], ent(9, 6, 1)); end
  endtask

  task automatic test_overflow();
    int k, cyc;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    for (int i = 0; i < 17; i++) rom[i] = ent(i + 1, 0, 8);
    model_song_start();
    model_pass(0, k);
    do_song_start(0);
    wait_idle(cyc);
    checks++; if (cyc != 70) begin errors++; $display("FAIL ovf_latency: got %0d expected 70", cyc); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    checks++; if (rom_addr !== 8'd17) begin errors++; $display("FAIL ovf_rom_addr: got %0d expected 17", rom_addr); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (notes[i] !== m_notes[i]) begin errors++; $display("FAIL ovf_slot %0d: got %h expected %h", i, notes[i], m_notes[i]); end
    end
    model_pass(1, k);
    do_new_beat(1);
    wait_idle(cyc);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end

    rom[0] = '0;
    model_song_start();
    model_pass(200, k);
    do_song_start(200);
    checks++; if (overflow !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ovf_clear_on_start: got ovf %b busy %b expected 0 1", overflow, busy); end
    wait_idle(cyc);
    checks++; if (cyc != 19) begin errors++; $display("FAIL end_marker_latency: got %0d expected 19", cyc); end
    checks++; if (notes !== '0 || rom_addr !== 8'd0 || overflow !== 1'b0) begin errors++; $display("FAIL end_marker_state: got notes %h addr %0d ovf %b expected 0 0 0", notes, rom_addr, overflow); end
  endtask

  task automatic test_no_wrap();
    int k, cyc;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[0] = ent(1, 250, 10);
    rom[1] = ent(2, 255, 255);
    model_song_start();
    model_pass(252, k);
    do_song_start(252);
    wait_idle(cyc);
    checks++; if (notes[0] !== ent(1, 250, 10) || notes[1] !== ent(2, 255, 255)) begin errors++; $display("FAIL wrap_load: got %h %h expected %h %h", notes[0], notes[1], ent(1, 250, 10), ent(2, 255, 255)); end
    model_pass(255, k);
    do_new_beat(255);
    wait_idle(cyc);
    checks++; if (cyc != 16 + 3 * k + 3) begin errors++; $display("FAIL wrap_latency: got %0d expected %0d", cyc, 16 + 3 * k + 3); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (notes[i] !== m_notes[i]) begin errors++; $display("FAIL wrap_slot %0d: got %h expected %h", i, notes[i], m_notes[i]); end
    end
  endtask

  task automatic test_pending();
    int k, cyc, b3;
    gen_rom(40, 2);
    b3 = int'($urandom_range(5, 20));
    model_song_start();
    model_pass(0, k);
    model_pass(b3, k);
    do_song_start(0);
    @(negedge clk);
    do_new_beat(int'($urandom_range(1, 4)));
    do_new_beat(int'($urandom_range(1, 4)));
    beat = 8'(b3);
    wait_idle(cyc);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pending_restart: got busy %b expected 1", busy); end
    wait_idle(cyc);
    checks++; if (cyc != 16 + 3 * k + 3) begin errors++; $display("FAIL pending_latency: got %0d expected %0d", cyc, 16 + 3 * k + 3); end
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pending_single_extra: got busy %b expected 0", busy); end
    checks++; if (rom_addr !== 8'(m_ptr)) begin errors++; $display("FAIL pending_rom_addr: got %0d expected %0d", rom_addr, m_ptr); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (notes[i] !== m_notes[i]) begin errors++; $display("FAIL pending_slot %0d: got %h expected %h", i, notes[i], m_notes[i]); end
    end
  endtask

  task automatic test_random();
    int k, cyc, b;
    gen_rom(60, 2);
    model_song_start();
    b = 0;
    model_pass(b, k);
    do_song_start(b);
    wait_idle(cyc);
    for (int it = 0; it < 14; it++) begin
      b += int'($urandom_range(1, 5));
      model_pass(b, k);
      do_new_beat(b);
      wait_idle(cyc);
      checks++; if (cyc != 16 + 3 * k + 3) begin errors++; $display("FAIL rand_latency beat %0d: got %0d expected %0d", b, cyc, 16 + 3 * k + 3); end
      checks++; if (rom_addr !== 8'(m_ptr)) begin errors++; $display("FAIL rand_rom_addr beat %0d: got %0d expected %0d", b, rom_addr, m_ptr); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow beat %0d: got %b expected %b", b, overflow, m_ovf); end
      for (int i = 0; i < 16; i++) begin
        checks++; if (notes[i] !== m_notes[i]) begin errors++; $display("FAIL rand_slot beat %0d slot %0d: got %h expected %h", b, i, notes[i], m_notes[i]); end
      end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    song_start = 1'b0;
    new_beat   = 1'b0;
    beat       = '0;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_no_wrap();
    test_pending();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
